// File: rtl/key_pkg.sv
// key_pkg: direction codes, PS/2 scan codes and prefix-FSM states for dir_key_decoder
package key_pkg;
  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  // Returns {hit, dir_id} for a byte against one up/left/down/right code set
  function automatic logic [2:0] dir_lookup(input logic [7:0] b, input logic [7:0] u,
                                            input logic [7:0] l, input logic [7:0] d,
                                            input logic [7:0] r);
    return b == u ? {1'b1, DIR_UP[1:0]} :
           b == l ? {1'b1, DIR_LEFT[1:0]} :
           b == d ? {1'b1, DIR_DOWN[1:0]} :
           b == r ? {1'b1, DIR_RIGHT[1:0]} : 3'b000;
  endfunction
endpackage

// File: rtl/dir_key_decoder_if.sv
// dir_key_decoder_if: PS/2 byte stream in, key/key_num direction interface out
interface dir_key_decoder_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       key;
  logic [2:0] key_num;
  modport master (output byte_valid, output byte_data, input key, input key_num);
  modport slave  (input byte_valid, input byte_data, output key, output key_num);
endinterface

// File: rtl/dir_stack.sv
// dir_stack: recency-ordered stack of held direction ids with depth counter
module dir_stack (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_remove,
  input  logic [1:0] i_id,
  output logic [1:0] o_top,
  output logic [2:0] o_depth
);
  logic [1:0] r_stk [4];
  logic [2:0] r_depth;
  logic [1:0] w_pos;
  // Locate the live slot holding the id being removed
  always_comb begin
    w_pos = 2'd0;
    for (int i = 0; i < 4; i++) if (r_stk[i] == i_id && 3'(i) < r_depth) w_pos = 2'(i);
  end
  // Push on top, or remove and shift the entries above it down one slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= 3'd0;
      for (int i = 0; i < 4; i++) r_stk[i] <= 2'd0;
    end else if (i_push) begin
      r_stk[r_depth[1:0]] <= i_id;
      r_depth <= r_depth + 3'd1;
    end else if (i_remove) begin
      for (int i = 0; i < 3; i++) if (2'(i) >= w_pos) r_stk[i] <= r_stk[i+1];
      r_depth <= r_depth - 3'd1;
    end
  end
  assign o_top   = r_stk[2'(r_depth - 3'd1)];
  assign o_depth = r_depth;
endmodule

// File: rtl/dir_key_decoder.sv
// dir_key_decoder: PS/2 scan codes to most-recent held direction; WASD keys when DIR_KEY_WASD_EN is defined
module dir_key_decoder
  import key_pkg::*;
(
  input logic          clk,
  input logic          rst,
  dir_key_decoder_if.slave bus
);
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_arrow_held, w_arrow_nxt, w_wasd_held, w_wasd_nxt, w_held_old, w_held_new;
  logic [2:0] w_arw, w_wsd, r_key_num, w_depth;
  logic [1:0] w_id, w_top;
  logic       w_ext, w_brk, w_pfx, w_done, w_push, w_remove;
  assign w_ext = r_state == ST_EXT || r_state == ST_EXT_BRK;
  assign w_brk = r_state == ST_BRK || r_state == ST_EXT_BRK;
  assign w_pfx = !w_brk && (bus.byte_data == SC_E0 || bus.byte_data == SC_F0);
  assign w_done = bus.byte_valid && !w_pfx;
  assign w_arw = w_ext ? dir_lookup(bus.byte_data, SC_UP, SC_LEFT, SC_DOWN, SC_RIGHT) : 3'b000;
`ifdef DIR_KEY_WASD_EN
  logic [3:0] r_wasd_held;
  assign w_wasd_held = r_wasd_held;
  assign w_wsd = w_ext ? 3'b000 : dir_lookup(bus.byte_data, SC_W, SC_A, SC_S, SC_D);
  // WASD source bits follow completed non-extended make/break codes
  always_ff @(posedge clk) begin
    if (rst) r_wasd_held <= 4'd0;
    else r_wasd_held <= w_wasd_nxt;
  end
`else
  assign w_wasd_held = 4'd0;
  assign w_wsd = 3'b000;
`endif
  // Next source-held bits and stack strobes from the completing byte
  always_comb begin
    w_arrow_nxt = r_arrow_held;
    w_wasd_nxt = w_wasd_held;
    if (w_done && w_arw[2]) w_arrow_nxt[w_arw[1:0]] = !w_brk;
    if (w_done && w_wsd[2]) w_wasd_nxt[w_wsd[1:0]] = !w_brk;
    w_id = w_arw[2] ? w_arw[1:0] : w_wsd[1:0];
    w_held_old = r_arrow_held | w_wasd_held;
    w_held_new = w_arrow_nxt | w_wasd_nxt;
    w_push = w_held_new[w_id] && !w_held_old[w_id];
    w_remove = !w_held_new[w_id] && w_held_old[w_id];
    w_state_nxt = !w_brk && bus.byte_data == SC_E0 ? ST_EXT :
                  !w_brk && bus.byte_data == SC_F0 ? (w_ext ? ST_EXT_BRK : ST_BRK) : ST_IDLE;
  end
  // Prefix FSM advances only on strobed bytes; arrow bits track completed codes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_arrow_held <= 4'd0;
    end else begin
      if (bus.byte_valid) r_state <= w_state_nxt;
      r_arrow_held <= w_arrow_nxt;
    end
  end
  dir_stack u_stack (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_remove (w_remove),
    .i_id     (w_id),
    .o_top    (w_top),
    .o_depth  (w_depth)
  );
  // Remember the last reported direction so key_num holds once the stack empties
  always_ff @(posedge clk) begin
    if (rst) r_key_num <= 3'd0;
    else if (w_depth != 3'd0) r_key_num <= {1'b0, w_top};
  end
  assign bus.key = w_depth != 3'd0;
  assign bus.key_num = w_depth != 3'd0 ? {1'b0, w_top} : r_key_num;
endmodule

// File: tb/tb_dir_key_decoder.sv
// tb_dir_key_decoder: table-driven byte vectors plus hand-written reset/gap/WASD sequences
module tb_dir_key_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       k;
    logic [2:0] n;
  } vec_t;
  vec_t tbl[$];
  dir_key_decoder_if bus ();
  dir_key_decoder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic k, input logic [2:0] n);
    tbl.push_back('{r: r, v: v, d: d, k: k, n: n});
  endtask
  task automatic press(input logic [7:0] d, input logic k, input logic [2:0] n);
    add(0, 1, 8'hE0, k, n);
  endtask
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic ek,
                      input logic [2:0] en, input string name);
    @(negedge clk);
    rst = r;
    bus.byte_valid = v;
    bus.byte_data = d;
    @(posedge clk);
    #1;
    n_run++;
    if (bus.key !== ek || bus.key_num !== en) begin
      n_fail++;
      $display("FAIL %s: got key=%0b key_num=%0d, want key=%0b key_num=%0d", name, bus.key, bus.key_num, ek, en);
    end
  endtask
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    add(1, 0, 8'h00, 0, 0);
    add(0, 1, 8'hE0, 0, 0); add(0, 1, 8'h75, 1, 0);
    add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'hF0, 1, 0); add(0, 1, 8'h75, 0, 0);
    add(0, 1, 8'hE0, 0, 0); add(0, 1, 8'h6B, 1, 1);
    add(0, 1, 8'hE0, 1, 1); add(0, 1, 8'h74, 1, 3);
    add(0, 1, 8'hE0, 1, 3); add(0, 1, 8'hF0, 1, 3); add(0, 1, 8'h74, 1, 1);
    add(0, 1, 8'hE0, 1, 1); add(0, 1, 8'hF0, 1, 1); add(0, 1, 8'h6B, 0, 1);
    add(0, 1, 8'hE0, 0, 1); add(0, 1, 8'h75, 1, 0);
    add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'h6B, 1, 1);
    add(0, 1, 8'hE0, 1, 1); add(0, 1, 8'h72, 1, 2);
    add(0, 1, 8'hE0, 1, 2); add(0, 1, 8'hF0, 1, 2); add(0, 1, 8'h6B, 1, 2);
    add(0, 1, 8'hE0, 1, 2); add(0, 1, 8'hF0, 1, 2); add(0, 1, 8'h72, 1, 0);
    add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'hF0, 1, 0); add(0, 1, 8'h75, 0, 0);
    add(0, 1, 8'hE0, 0, 0); add(0, 1, 8'h75, 1, 0);
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'h75, 1, 0);
    end
    add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'hF0, 1, 0); add(0, 1, 8'h75, 0, 0);
    add(0, 1, 8'h75, 0, 0); add(0, 1, 8'hF0, 0, 0); add(0, 1, 8'h75, 0, 0);
    add(0, 1, 8'hE0, 0, 0); add(0, 1, 8'hF0, 0, 0); add(0, 1, 8'h6B, 0, 0);
    add(0, 1, 8'hE0, 0, 0); add(0, 1, 8'h75, 1, 0);
    add(0, 1, 8'hE0, 1, 0); add(0, 1, 8'h6B, 1, 1);
    add(0, 1, 8'hE0, 1, 1); add(0, 1, 8'h72, 1, 2);
    add(0, 1, 8'hE0, 1, 2); add(0, 1, 8'h74, 1, 3);
    add(0, 1, 8'hE0, 1, 3); add(0, 1, 8'h6B, 1, 3);
    add(0, 1, 8'hE0, 1, 3); add(0, 1, 8'hF0, 1, 3); add(0, 1, 8'h75, 1, 3);
    add(0, 1, 8'hE0, 1, 3); add(0, 1, 8'hF0, 1, 3); add(0, 1, 8'h72, 1, 3);
    add(0, 1, 8'hE0, 1, 3); add(0, 1, 8'hF0, 1, 3); add(0, 1, 8'h74, 1, 1);
    add(0, 1, 8'hE1, 1, 1); add(0, 1, 8'h14, 1, 1);
    add(0, 1, 8'hE0, 1, 1); add(0, 1, 8'hF0, 1, 1); add(0, 1, 8'h6B, 0, 1);
    add(0, 1, 8'hE0, 0, 1); add(0, 1, 8'hF0, 0, 1); add(0, 1, 8'h75, 0, 1);
    add(0, 1, 8'hE0, 0, 1); add(0, 1, 8'hE0, 0, 1); add(0, 1, 8'h72, 1, 2);
    foreach (tbl[i]) step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].n, $sformatf("vec%0d", i));
    step(1, 0, 8'h00, 0, 0, "rst_clears_held");
    step(0, 1, 8'hE0, 0, 0, "rstmid_e0");
    step(0, 1, 8'hF0, 0, 0, "rstmid_f0");
    step(1, 0, 8'h00, 0, 0, "rstmid_rst");
    step(0, 1, 8'h6B, 0, 0, "rstmid_plain_6b");
    step(0, 1, 8'hE0, 0, 0, "gap_e0");
    step(0, 0, 8'hF0, 0, 0, "gap_idle_f0");
    step(0, 0, 8'h75, 0, 0, "gap_idle_75");
    step(0, 1, 8'h74, 1, 3, "gap_right_make");
    step(0, 0, 8'hE0, 1, 3, "gap_hold");
    step(0, 1, 8'hE0, 1, 3, "gap_rel_e0");
    step(0, 1, 8'hF0, 1, 3, "gap_rel_f0");
    step(0, 1, 8'h74, 0, 3, "gap_rel_right");
`ifdef DIR_KEY_WASD_EN
    step(0, 1, 8'h1D, 1, 0, "wasd_w_make");
    step(0, 1, 8'hE0, 1, 0, "wasd_e0");
    step(0, 1, 8'h75, 1, 0, "wasd_up_second_src");
    step(0, 1, 8'hF0, 1, 0, "wasd_f0");
    step(0, 1, 8'h1D, 1, 0, "wasd_w_break_arrow_holds");
    step(0, 1, 8'h1C, 1, 1, "wasd_a_make");
    step(0, 1, 8'hE0, 1, 1, "wasd_ext_e0");
    step(0, 1, 8'h23, 1, 1, "wasd_ext_d_ignored");
    step(0, 1, 8'hF0, 1, 1, "wasd_a_f0");
    step(0, 1, 8'h1C, 1, 0, "wasd_a_break");
    step(0, 1, 8'hE0, 1, 0, "wasd_up_e0");
    step(0, 1, 8'hF0, 1, 0, "wasd_up_f0");
    step(0, 1, 8'h75, 0, 0, "wasd_up_break");
`else
    step(0, 1, 8'h1D, 0, 3, "nowasd_w_ignored");
    step(0, 1, 8'h23, 0, 3, "nowasd_d_ignored");
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
